// File: rtl/dmem_bank.sv
// Single-port synchronous data-memory bank: byte-enable writes, 1/2-cycle reads,
// range-checked requests and a post-reset zero-fill. Define DMEM_PARITY_EN for per-lane parity.
//
// state | meaning
// INIT  | zero-fill sequencer writing word cnt, requests blocked
// RUN   | accepting one request per cycle
module dmem_bank #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 32,
    parameter int READ_LAT  = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  resp_perr,
    output logic                  init_busy
);
    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state;
    logic [AW-1:0]      cnt;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               accept;
    logic [AW-1:0]      idx;
    logic               range_err;
    logic               do_write;
    logic               rd_ok;
    logic               rd_perr;
    logic [DATA_W-1:0]  s_rdata;
    logic               s_perr;
    logic               addr_lsb_unused;

    assign accept          = req_valid & req_ready;
    assign idx             = req_addr[AW+1:2];
    assign range_err       = |req_addr[ADDR_W-1:AW+2];
    assign do_write        = accept & req_we & ~range_err;
    assign rd_ok           = ~req_we & ~range_err;
    assign addr_lsb_unused = ^req_addr[1:0];

    // Read-old: the registered response samples the array before this edge's write.
    assign s_rdata = rd_ok ? mem[idx] : '0;
    assign s_perr  = rd_ok & rd_perr;

`ifdef DMEM_PARITY_EN
    logic [NB-1:0] mem_par [DEPTH];

    always_comb begin
        rd_perr = 1'b0;
        for (int i = 0; i < NB; i++) begin
            rd_perr = rd_perr | ((^mem[idx][8*i +: 8]) ^ mem_par[idx][i]);
        end
    end
`else
    assign rd_perr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[cnt] <= '0;
`ifdef DMEM_PARITY_EN
            mem_par[cnt] <= '0;
`endif
        end else if (do_write) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
`ifdef DMEM_PARITY_EN
                    mem_par[idx][i] <= ^req_wdata[8*i +: 8];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            cnt       <= '0;
            req_ready <= 1'b0;
            init_busy <= (INIT_ZERO != 0);
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state     <= ST_RUN;
                        req_ready <= 1'b1;
                        init_busy <= 1'b0;
                    end
                end
                default: begin
                    req_ready <= 1'b1;
                    init_busy <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              p_valid;
            logic              p_err;
            logic              p_perr;
            logic [DATA_W-1:0] p_rdata;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    p_valid    <= 1'b0;
                    p_err      <= 1'b0;
                    p_perr     <= 1'b0;
                    p_rdata    <= '0;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_perr  <= 1'b0;
                    resp_rdata <= '0;
                end else begin
                    p_valid <= accept;
                    if (accept) begin
                        p_err   <= range_err;
                        p_perr  <= s_perr;
                        p_rdata <= s_rdata;
                    end
                    resp_valid <= p_valid;
                    if (p_valid) begin
                        resp_err   <= p_err;
                        resp_perr  <= p_perr;
                        resp_rdata <= p_rdata;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_perr  <= 1'b0;
                    resp_rdata <= '0;
                end else begin
                    resp_valid <= accept;
                    if (accept) begin
                        resp_err   <= range_err;
                        resp_perr  <= s_perr;
                        resp_rdata <= s_rdata;
                    end
                end
            end
        end
    endgenerate

endmodule
